uart_rx_checked: RTL
====================

// Module: uart_rx_checked
// PURPOSE
//  UART receive end with error checking and a one-word holding register. Takes the
//  serial rx line and the 16x oversampling s_tick from the shared baud generator
//  (mod_m_counter). Delivers each received word with valid/read handshake,
//  framing-error and overrun flags, and optional parity check.
//  Sits beside uart_tx/uart_rx in the uart top; a drop-in, host-readable receiver.
// PARAMETERS
//  D_BIT       8   number of data bits per frame (LSB first)
//  SB_TICK     16  s_ticks in stop bit (16/24/32 = 1/1.5/2 stop bits)
//  PARITY_ODD  0   0 = even parity, 1 = odd parity (used only with UART_PARITY_EN)
// PORTS
//  clk           in   1      system clock
//  reset         in   1      asynchronous, active-high reset
//  rx            in   1      serial input, idle high; asynchronous to clk
//  s_tick        in   1      1-clk enable pulse, 16 per bit period
//  rd_uart       in   1      host read: clears rx_valid and overrun
//  dout          out  D_BIT  last received word
//  rx_valid      out  1      dout holds an unread word
//  rx_done_tick  out  1      1-clk pulse per completed frame (good or bad)
//  frame_err     out  1      stop bit of last frame sampled 0
//  parity_err    out  1      parity mismatch on last frame
//  overrun       out  1      word completed while previous one unread (sticky)
// BEHAVIOUR
//  Reset: state=IDLE, tick count s=0, bit count n=0, shift reg b=0, sync FFs=1,
//   dout=0, rx_valid=0, rx_done_tick=0, frame_err=0, parity_err=0, overrun=0.
//  rx passes through a 2-FF synchronizer (rx_s); all sampling uses rx_s.
//  s counts s_ticks (4 bits); n counts data bits (log2 D_BIT bits).
//  IDLE: rx_s==0 -> START, s=0. s_tick ignored otherwise.
//  START: on s_tick: s==7 -> if rx_s==0 go DATA, s=0, n=0; else go IDLE
//   (glitch, no done pulse, no flag change). Otherwise s++.
//  DATA: on s_tick: s==15 -> s=0, b={rx_s,b[D_BIT-1:1]};
//   n==D_BIT-1 -> PARITY (macro on) / STOP (macro off), else n++. Otherwise s++.
//  PARITY: on s_tick at s==15: capture p=rx_s, s=0 -> STOP.
//  STOP: on s_tick at s==SB_TICK-1: go IDLE; at that edge dout<=b,
//   frame_err<=~rx_s, parity_err<=computed, rx_done_tick<=1 (one clk only).
//  Latency: stop-sample s_tick edge -> dout/flags/rx_done_tick valid next cycle.
//  Holding reg: on completion rx_valid<=1; if rx_valid==1 and rd_uart==0 that
//   cycle, overrun<=1 and dout is overwritten with the new word.
//  rd_uart alone: rx_valid<=0, overrun<=0. rd_uart with completion in same cycle:
//   new word loaded, rx_valid stays 1, overrun<=0.
//  rd_uart while rx_valid==0: no effect. Flags frame_err/parity_err hold until
//   next completed frame. Bad frames still load dout and set rx_valid.
//  Break (rx held 0): one frame with b=0, frame_err=1; IDLE then waits for
//   rx_s==0 again, i.e. re-triggers immediately; each frame reported separately.
//  Reset mid-frame: returns to IDLE at once; partial word discarded.
// CONFIGURATION
//  UART_PARITY_EN defined: PARITY state present; frame = start+D_BIT+parity+stop;
//   parity_err = (^b ^ p) != PARITY_ODD.
//  UART_PARITY_EN undefined: PARITY state and p removed; DATA goes to STOP;
//   parity_err tied 0; PARITY_ODD unused.
// TESTING  (DVSR reduced for sim; frames driven by uart_tx or bench model)
//  frame 0xA5, good stop -> 1 rx_done_tick, dout=0xA5, rx_valid=1, errs=0.
//  frame 0x3C with stop bit 0 -> dout=0x3C, frame_err=1; next good frame clears it.
//  rx low for 4 s_ticks then high -> no rx_done_tick, state back to IDLE, flags unchanged.
//  0x11 then 0x22, no rd_uart -> dout=0x22, overrun=1; rd_uart -> rx_valid=0, overrun=0.
//  UART_PARITY_EN, even: 0x07 + p=1 -> parity_err=0; 0x07 + p=0 -> parity_err=1.
//  reset pulse mid DATA, then frame 0x5A -> no output before reset, dout=0x5A after.

Source files
------------

// File: rtl/uart_rx_checked.sv
// uart_rx_checked: UART receiver with a 2-FF input synchronizer, 16x oversampled
// bit recovery, a one-word holding register (rx_valid/rd_uart handshake) and
// framing-error, parity-error and sticky overrun flags.
// Optional parity bit between the last data bit and the stop bit is enabled by
// defining UART_PARITY_EN; without it the parity state is absent and parity_err
// stays 0.
module uart_rx_checked #(
  parameter int unsigned D_BIT      = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  input  logic             s_tick,
  input  logic             rd_uart,
  output logic [D_BIT-1:0] dout,
  output logic             rx_valid,
  output logic             rx_done_tick,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int unsigned NW = (D_BIT > 1) ? $clog2(D_BIT) : 1;
  // Tick counter is 4 bits for one stop bit, widened for 1.5/2 stop bits.
  localparam int unsigned SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

  localparam logic [NW-1:0] N_LAST  = NW'(D_BIT - 1);
  localparam logic [SW-1:0] S_MID   = SW'(7);
  localparam logic [SW-1:0] S_LAST  = SW'(15);
  localparam logic [SW-1:0] S_STOP  = SW'(SB_TICK - 1);
  localparam logic          PAR_ODD = (PARITY_ODD != 0);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [D_BIT-1:0] b;
  logic            rx_meta;
  logic            rx_s;
`ifdef UART_PARITY_EN
  logic            p;
`endif

  // Two-stage synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM, shift register and host-side holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
`ifdef UART_PARITY_EN
      p            <= 1'b0;
`endif
      dout         <= '0;
      rx_valid     <= 1'b0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      parity_err   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;

      // Host read of a pending word; a completing frame below takes precedence.
      if (rd_uart && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end

        START: begin
          if (s_tick) begin
            if (s == S_MID) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end

        DATA: begin
          if (s_tick) begin
            if (s == S_LAST) begin
              s <= '0;
              b <= {rx_s, b[D_BIT-1:1]};
              if (n == N_LAST) begin
`ifdef UART_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end

`ifdef UART_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (s == S_LAST) begin
              p     <= rx_s;
              s     <= '0;
              state <= STOP;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`endif

        STOP: begin
          if (s_tick) begin
            if (s == S_STOP) begin
              state        <= IDLE;
              dout         <= b;
              frame_err    <= ~rx_s;
`ifdef UART_PARITY_EN
              parity_err   <= (((^b) ^ p) != PAR_ODD);
`else
              parity_err   <= 1'b0 & PAR_ODD;
`endif
              rx_done_tick <= 1'b1;
              rx_valid     <= 1'b1;
              if (rd_uart) begin
                overrun <= 1'b0;
              end else if (rx_valid) begin
                overrun <= 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
